// File: rtl/fifo_read_serializer_pkg.sv
// Shared helpers for the FIFO read serializer: slice-count derivation and
// the width sanity check applied when the block is elaborated.
package fifo_read_serializer_pkg;

  // Counter width for n states; a 1-bit counter is kept even when n == 1.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int calc_ratio(input int dw, input int ow);
    return dw / ow;
  endfunction

  function automatic bit widths_ok(input int dw, input int ow);
    return (ow > 0) && (dw >= ow) && ((dw % ow) == 0);
  endfunction

endpackage

// File: rtl/fifo_read_serializer_if.sv
// FIFO read port plus narrow valid/ready slice stream seen by the serializer.
interface fifo_read_serializer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8
);
  logic                  fifo_rEn;
  logic [DATA_WIDTH-1:0] fifo_rData;
  logic                  fifo_empty;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_WIDTH-1:0]  out_data;
  logic                  out_last;

  modport master (
    output fifo_rEn, out_valid, out_data, out_last,
    input  fifo_rData, fifo_empty, flush, out_ready
  );

  modport slave (
    input  fifo_rEn, out_valid, out_data, out_last,
    output fifo_rData, fifo_empty, flush, out_ready
  );
endinterface

// File: rtl/fifo_read_serializer.sv
// Pops wide words from a show-ahead sync FIFO and streams them out as
// RATIO narrow slices, reloading on the last slice so words run back-to-back.
module fifo_read_serializer
  import fifo_read_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                    clk,
  input  logic                    arst_n,
  fifo_read_serializer_if.master  bus
);

  localparam int RATIO = calc_ratio(DATA_WIDTH, OUT_WIDTH);
  localparam int CW    = clog2_min1(RATIO);
  localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);

  if (!widths_ok(DATA_WIDTH, OUT_WIDTH)) begin : g_bad_width
    $error("fifo_read_serializer: DATA_WIDTH must be a multiple of OUT_WIDTH");
  end

  logic [DATA_WIDTH-1:0]            hold_q;
  logic                             hold_vld;
  logic [CW-1:0]                    cnt;
  logic [RATIO-1:0][OUT_WIDTH-1:0]  slices;
  logic [CW-1:0]                    sel;
  logic                             last;
  logic                             accept;
  logic                             pop;

  assign slices = hold_q;
  assign sel    = MSB_FIRST ? (LAST_CNT - cnt) : cnt;
  assign last   = hold_vld && (cnt == LAST_CNT);
  assign accept = hold_vld && bus.out_ready;

  // Refill when idle or when the last slice leaves; never pop an empty FIFO.
  assign pop = !bus.fifo_empty && !bus.flush && (!hold_vld || (accept && last));

  assign bus.fifo_rEn  = pop;
  assign bus.out_valid = hold_vld;
  assign bus.out_data  = slices[sel];
  assign bus.out_last  = last;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      hold_q   <= '0;
      hold_vld <= 1'b0;
      cnt      <= '0;
    end else if (bus.flush) begin
      // Flush wins over any accept or pop in the same cycle.
      hold_vld <= 1'b0;
      cnt      <= '0;
    end else if (pop) begin
      hold_q   <= bus.fifo_rData;
      hold_vld <= 1'b1;
      cnt      <= '0;
    end else if (accept) begin
      if (last) begin
        hold_vld <= 1'b0;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_read_serializer.sv
// Directed bench: two serializers (LSB-first and MSB-first) fed by queue-based
// show-ahead FIFO models, with a slice scoreboard checked on every accept.
module tb_fifo_read_serializer;

  logic clk;
  logic arst_n;
  int   total;
  int   bad;

  fifo_read_serializer_if #(.DATA_WIDTH(32), .OUT_WIDTH(8)) b1 ();
  fifo_read_serializer_if #(.DATA_WIDTH(32), .OUT_WIDTH(8)) b2 ();

  fifo_read_serializer #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .arst_n(arst_n), .bus(b1)
  );
  fifo_read_serializer #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) dut2 (
    .clk(clk), .arst_n(arst_n), .bus(b2)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } slice_t;

  slice_t      exp1[$];
  slice_t      exp2[$];
  logic [31:0] fq1[$];
  logic [31:0] fq2[$];
  int          ren1;
  int          ren2;
  logic        p1;
  logic        p2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic upd();
    b1.fifo_empty = (fq1.size() == 0);
    b1.fifo_rData = (fq1.size() == 0) ? 32'hDEADBEEF : fq1[0];
    b2.fifo_empty = (fq2.size() == 0);
    b2.fifo_rData = (fq2.size() == 0) ? 32'hDEADBEEF : fq2[0];
  endtask

  task automatic mon();
    slice_t s;
    if (b1.fifo_rEn) begin
      ren1++;
      chk("underflow1", 32'(b1.fifo_empty), 32'd0);
    end
    if (b2.fifo_rEn) begin
      ren2++;
      chk("underflow2", 32'(b2.fifo_empty), 32'd0);
    end
    if (b1.out_valid && b1.out_ready) begin
      chk("sb1_extra", 32'(exp1.size() != 0), 32'd1);
      if (exp1.size() != 0) begin
        s = exp1.pop_front();
        chk("data1", 32'(b1.out_data), 32'(s.d));
        chk("last1", 32'(b1.out_last), 32'(s.l));
      end
    end
    if (b2.out_valid && b2.out_ready) begin
      chk("sb2_extra", 32'(exp2.size() != 0), 32'd1);
      if (exp2.size() != 0) begin
        s = exp2.pop_front();
        chk("data2", 32'(b2.out_data), 32'(s.d));
        chk("last2", 32'(b2.out_last), 32'(s.l));
      end
    end
  endtask

  // One clock: score accepts at negedge, pop the FIFO models just after posedge.
  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    p1 = b1.fifo_rEn;
    p2 = b2.fifo_rEn;
    #1;
    if (p1 && fq1.size() != 0) void'(fq1.pop_front());
    if (p2 && fq2.size() != 0) void'(fq2.pop_front());
    upd();
  endtask

  task automatic expect_slice(input int which, input logic [7:0] d, input logic l);
    slice_t s;
    s.d = d;
    s.l = l;
    if (which == 1) exp1.push_back(s);
    else exp2.push_back(s);
  endtask

  task automatic push(input int which, input logic [31:0] w, input bit with_exp);
    if (which == 1) fq1.push_back(w);
    else fq2.push_back(w);
    if (with_exp)
      for (int i = 0; i < 4; i++)
        expect_slice(which, (which == 1) ? w[8*i +: 8] : w[8*(3-i) +: 8], i == 3);
    upd();
  endtask

  task automatic drain(input int which, output int n);
    n = 0;
    while (((which == 1) ? exp1.size() : exp2.size()) != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'((which == 1) ? exp1.size() : exp2.size()), 32'd0);
  endtask

  initial begin
    int n;
    int r0;
    bit anyv;
    total = 0;
    bad   = 0;
    ren1  = 0;
    ren2  = 0;
    arst_n = 1'b0;
    b1.flush = 1'b0;
    b1.out_ready = 1'b0;
    b2.flush = 1'b0;
    b2.out_ready = 1'b0;
    upd();
    repeat (2) tick();

    chk("rst_valid", 32'(b1.out_valid), 32'd0);
    chk("rst_last",  32'(b1.out_last),  32'd0);
    chk("rst_data",  32'(b1.out_data),  32'd0);
    chk("rst_ren",   32'(b1.fifo_rEn),  32'd0);
    arst_n = 1'b1;
    tick();

    // single word, full rate
    b1.out_ready = 1'b1;
    r0 = ren1;
    push(1, 32'hDDCCBBAA, 1'b1);
    drain(1, n);
    chk("single_lat",  32'(n), 32'd5);
    chk("single_ren",  32'(ren1 - r0), 32'd1);
    chk("single_idle", 32'(b1.out_valid), 32'd0);

    // back-to-back words, no bubble between them
    r0 = ren1;
    push(1, 32'h44332211, 1'b1);
    push(1, 32'h88776655, 1'b1);
    drain(1, n);
    chk("b2b_lat",  32'(n), 32'd9);
    chk("b2b_ren",  32'(ren1 - r0), 32'd2);
    chk("b2b_idle", 32'(b1.out_valid), 32'd0);

    // backpressure mid-word and on the last slice with a word queued behind
    r0 = ren1;
    push(1, 32'h0D0C0B0A, 1'b1);
    push(1, 32'h14131211, 1'b1);
    tick();
    tick();
    b1.out_ready = 1'b0;
    #1;
    chk("bp_data_a", 32'(b1.out_data), 32'h0B);
    chk("bp_ren_a",  32'(b1.fifo_rEn), 32'd0);
    tick();
    chk("bp_data_b",  32'(b1.out_data),  32'h0B);
    chk("bp_valid_b", 32'(b1.out_valid), 32'd1);
    tick();
    chk("bp_data_c", 32'(b1.out_data), 32'h0B);
    b1.out_ready = 1'b1;
    tick();
    tick();
    b1.out_ready = 1'b0;
    #1;
    chk("bp_last_data", 32'(b1.out_data), 32'h0D);
    chk("bp_last_flag", 32'(b1.out_last), 32'd1);
    chk("bp_last_ren",  32'(b1.fifo_rEn), 32'd0);
    tick();
    chk("bp_last_hold", 32'(b1.out_data), 32'h0D);
    b1.out_ready = 1'b1;
    #1;
    chk("bp_reload_ren", 32'(b1.fifo_rEn), 32'd1);
    drain(1, n);
    chk("bp_ren", 32'(ren1 - r0), 32'd2);

    // empty source
    r0 = ren1;
    anyv = 1'b0;
    repeat (20) begin
      tick();
      if (b1.out_valid) anyv = 1'b1;
    end
    chk("empty_ren",   32'(ren1 - r0), 32'd0);
    chk("empty_flag",  32'(b1.fifo_empty), 32'd1);
    chk("empty_valid", 32'(anyv), 32'd0);

    // flush held while idle blocks the pop
    b1.flush = 1'b1;
    push(1, 32'h78563412, 1'b1);
    #1;
    chk("flush_nopop", 32'(b1.fifo_rEn), 32'd0);
    tick();
    chk("flush_idle", 32'(b1.out_valid), 32'd0);
    b1.flush = 1'b0;
    drain(1, n);

    // flush after two slices; the queued word starts cleanly
    push(1, 32'hDDCCBBAA, 1'b0);
    expect_slice(1, 8'hAA, 1'b0);
    expect_slice(1, 8'hBB, 1'b0);
    push(1, 32'h44332211, 1'b1);
    tick();
    tick();
    tick();
    chk("flush_cc", 32'(b1.out_data), 32'hCC);
    b1.flush = 1'b1;
    b1.out_ready = 1'b0;
    tick();
    chk("flush_clr", 32'(b1.out_valid), 32'd0);
    b1.flush = 1'b0;
    b1.out_ready = 1'b1;
    #1;
    chk("flush_refill", 32'(b1.fifo_rEn), 32'd1);
    drain(1, n);

    // MSB-first ordering
    b2.out_ready = 1'b1;
    r0 = ren2;
    push(2, 32'hDDCCBBAA, 1'b1);
    drain(2, n);
    chk("msb_lat", 32'(n), 32'd5);
    chk("msb_ren", 32'(ren2 - r0), 32'd1);

    // async reset mid-word drops the partial word
    push(2, 32'h04030201, 1'b0);
    expect_slice(2, 8'h04, 1'b0);
    expect_slice(2, 8'h03, 1'b0);
    tick();
    tick();
    tick();
    chk("mid_valid", 32'(b2.out_valid), 32'd1);
    arst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(b2.out_valid), 32'd0);
    chk("arst_last",  32'(b2.out_last),  32'd0);
    chk("arst_data",  32'(b2.out_data),  32'd0);
    chk("arst_sb",    32'(exp2.size()),  32'd0);
    tick();
    arst_n = 1'b1;
    tick();
    push(2, 32'hA4A3A2A1, 1'b1);
    drain(2, n);
    chk("post_rst_lat", 32'(n), 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
